// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR multi-block AES-128 encryption controller with an embedded iterative round engine.
// Optional macro AES_MODE_CTR_EN enables CTR mode; otherwise mode 2'b10 is rejected like 2'b11.
module aes_mode_ctrl #(
    parameter int unsigned KEY_LEN       = 128,
    parameter int unsigned DATA_LEN      = 128,
    parameter int unsigned NUMS_OF_ROUND = 10,
    parameter int unsigned MAX_BLOCKS    = 16,
    localparam int unsigned CW           = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [KEY_LEN-1:0]  cipher_key,
    input  logic [DATA_LEN-1:0] iv,
    input  logic [CW-1:0]       num_blocks,
    input  logic                blk_in_valid,
    output logic                blk_in_ready,
    input  logic [DATA_LEN-1:0] plain_text,
    output logic                blk_out_valid,
    input  logic                blk_out_ready,
    output logic [DATA_LEN-1:0] cipher_text,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned RW       = $clog2(NUMS_OF_ROUND + 1);
    localparam logic [1:0]  MODE_ECB = 2'b00;
    localparam logic [1:0]  MODE_CBC = 2'b01;
`ifdef AES_MODE_CTR_EN
    localparam logic [1:0]  MODE_CTR = 2'b10;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_e;

    // GF(2^8) arithmetic and the AES-128 round / key-schedule step
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [DATA_LEN-1:0] aes_round(input logic [DATA_LEN-1:0] st,
                                                      input logic [DATA_LEN-1:0] rk,
                                                      input logic            last);
        logic [DATA_LEN-1:0] sb, sr, mx;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        mx = sr;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = sr[127-32*c -: 8];
                a1 = sr[119-32*c -: 8];
                a2 = sr[111-32*c -: 8];
                a3 = sr[103-32*c -: 8];
                mx[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                mx[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                mx[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                mx[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return mx ^ rk;
    endfunction

    function automatic logic [KEY_LEN-1:0] key_step(input logic [KEY_LEN-1:0] rk,
                                                    input logic [7:0]         rcon);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {rk[23:0], rk[31:24]};
        t   = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = rk[127:96] ^ t;
        n1  = rk[95:64] ^ n0;
        n2  = rk[63:32] ^ n1;
        n3  = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_e                state_q, state_d;
    logic [KEY_LEN-1:0]    key_q, key_d;
    logic [DATA_LEN-1:0]   chain_q, chain_d;
    logic [CW-1:0]         remaining_q, remaining_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_LEN-1:0]   core_in_q, core_in_d;
    logic [DATA_LEN-1:0]   ct_q, ct_d;
    logic                  core_valid_q, core_valid_d;
    logic                  blk_in_ready_q, blk_in_ready_d;
    logic                  blk_out_valid_q, blk_out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  illegal_mode;
`ifdef AES_MODE_CTR_EN
    logic [DATA_LEN-1:0]   pt_q, pt_d;
`endif

    // Round engine: one round per cycle after an issue pulse, one-cycle valid on completion
    logic [DATA_LEN-1:0]   aes_st_q, aes_st_d;
    logic [KEY_LEN-1:0]    aes_rk_q, aes_rk_d, aes_rk_nx;
    logic [7:0]            aes_rcon_q, aes_rcon_d;
    logic [RW-1:0]         aes_round_q, aes_round_d;
    logic                  aes_run_q, aes_run_d;
    logic                  aes_vout_q, aes_vout_d;

    always_comb begin
        aes_st_d    = aes_st_q;
        aes_rk_d    = aes_rk_q;
        aes_rcon_d  = aes_rcon_q;
        aes_round_d = aes_round_q;
        aes_run_d   = aes_run_q;
        aes_vout_d  = 1'b0;
        aes_rk_nx   = key_step(aes_rk_q, aes_rcon_q);
        if (core_valid_q) begin
            aes_st_d    = core_in_q ^ key_q;
            aes_rk_d    = key_q;
            aes_rcon_d  = 8'h01;
            aes_round_d = RW'(1);
            aes_run_d   = 1'b1;
        end else if (aes_run_q) begin
            aes_st_d    = aes_round(aes_st_q, aes_rk_nx, aes_round_q == RW'(NUMS_OF_ROUND));
            aes_rk_d    = aes_rk_nx;
            aes_rcon_d  = xtime(aes_rcon_q);
            aes_round_d = aes_round_q + RW'(1);
            if (aes_round_q == RW'(NUMS_OF_ROUND)) begin
                aes_run_d  = 1'b0;
                aes_vout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aes_st_q    <= '0;
            aes_rk_q    <= '0;
            aes_rcon_q  <= '0;
            aes_round_q <= '0;
            aes_run_q   <= 1'b0;
            aes_vout_q  <= 1'b0;
        end else begin
            aes_st_q    <= aes_st_d;
            aes_rk_q    <= aes_rk_d;
            aes_rcon_q  <= aes_rcon_d;
            aes_round_q <= aes_round_d;
            aes_run_q   <= aes_run_d;
            aes_vout_q  <= aes_vout_d;
        end
    end

`ifdef AES_MODE_CTR_EN
    assign illegal_mode = (mode == 2'b11);
`else
    assign illegal_mode = mode[1];
`endif

    // Message sequencing; registered outputs are decoded from the next state
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        chain_d     = chain_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        core_in_d   = core_in_q;
        ct_d        = ct_q;
        err_d       = 1'b0;
`ifdef AES_MODE_CTR_EN
        pt_d        = pt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (illegal_mode) begin
                        err_d = 1'b1;
                    end else if (num_blocks == '0) begin
                        state_d = DONE;
                    end else begin
                        key_d       = cipher_key;
                        chain_d     = iv;
                        remaining_d = num_blocks;
                        mode_d      = mode;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                if (blk_in_valid) begin
`ifdef AES_MODE_CTR_EN
                    pt_d = plain_text;
`endif
                    case (mode_q)
                        MODE_CBC: core_in_d = plain_text ^ chain_q;
`ifdef AES_MODE_CTR_EN
                        MODE_CTR: core_in_d = chain_q;
`endif
                        default:  core_in_d = plain_text;
                    endcase
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (aes_vout_q) begin
                    ct_d = aes_st_q;
                    if (mode_q == MODE_CBC) chain_d = aes_st_q;
`ifdef AES_MODE_CTR_EN
                    if (mode_q == MODE_CTR) begin
                        ct_d          = aes_st_q ^ pt_q;
                        chain_d[31:0] = chain_q[31:0] + 32'd1;
                    end
`endif
                    remaining_d = remaining_q - CW'(1);
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (blk_out_ready) state_d = (remaining_q == '0) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        core_valid_d    = (state_d == ISSUE);
        blk_in_ready_d  = (state_d == LOAD);
        blk_out_valid_d = (state_d == OUT);
        busy_d          = (state_d != IDLE);
        done_d          = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            key_q           <= '0;
            chain_q         <= '0;
            remaining_q     <= '0;
            mode_q          <= MODE_ECB;
            core_in_q       <= '0;
            ct_q            <= '0;
            core_valid_q    <= 1'b0;
            blk_in_ready_q  <= 1'b0;
            blk_out_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
`ifdef AES_MODE_CTR_EN
            pt_q            <= '0;
`endif
        end else begin
            state_q         <= state_d;
            key_q           <= key_d;
            chain_q         <= chain_d;
            remaining_q     <= remaining_d;
            mode_q          <= mode_d;
            core_in_q       <= core_in_d;
            ct_q            <= ct_d;
            core_valid_q    <= core_valid_d;
            blk_in_ready_q  <= blk_in_ready_d;
            blk_out_valid_q <= blk_out_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
`ifdef AES_MODE_CTR_EN
            pt_q            <= pt_d;
`endif
        end
    end

    assign blk_in_ready  = blk_in_ready_q;
    assign blk_out_valid = blk_out_valid_q;
    assign cipher_text   = ct_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
